commit_monitor: RTL
===================

COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 Parameter COMMIT_W, default 2, sets the number of commit lanes per cycle (1..4).
REQ-002 Parameter TRACE_DEPTH, default 16, sets trace FIFO entries (power of two, >= COMMIT_W).
REQ-003 Parameter WDOG_CYCLES, default 1024, sets the number of commit-free cycles before hang is flagged.
REQ-004 Parameter PREG_W, default 7, sets the physical register tag width.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 commit_valid  in  COMMIT_W  per-lane retire strobe; lanes are in program order, lane 0 oldest.
REQ-008 commit_pc  in  COMMIT_W x 32  retiring PC per lane.
REQ-009 commit_we / commit_areg / commit_preg / commit_data  in  COMMIT_W x {1,5,PREG_W,32}  per-lane destination write info.
REQ-010 mispredict  in  1  one-cycle flush pulse.
REQ-011 trace_rd  in  1  pop request; trace_valid/trace_pc/trace_areg/trace_data  out  {1,32,5,32}  FIFO head.
REQ-012 trace_count  out  $clog2(TRACE_DEPTH)+1  occupancy; trace_overflow  out  1  sticky drop flag.
REQ-013 retired_count  out  32; mispredict_count  out  16; hang  out  1; mon_state  out  2.
REQ-014 arch_rd_areg  in  5; arch_rd_data  out  32  architectural value query.

Function
REQ-015 FSM states: IDLE(0), RUN(1), HUNG(2); IDLE->RUN on any commit_valid bit; RUN->HUNG when the watchdog counter reaches WDOG_CYCLES-1 with no commit; HUNG->RUN on any commit.
REQ-016 Watchdog counter clears on any commit cycle, increments otherwise in RUN, and holds in IDLE/HUNG; hang = (state==HUNG), registered.
REQ-017 retired_count adds popcount(commit_valid) each cycle, wrapping modulo 2^32.
REQ-018 mispredict_count increments on each mispredict cycle and saturates at 0xFFFF.
REQ-019 Every valid lane is pushed to the trace FIFO in lane order, one cycle after commit (1-cycle latency to trace_valid).
REQ-020 Pop takes effect in the same cycle as push: free = TRACE_DEPTH - trace_count + (trace_rd & trace_valid).
REQ-021 If the valid lanes exceed free space, the oldest lanes that fit are kept, the younger ones are dropped, and trace_overflow is set (sticky until reset).
REQ-022 trace_rd while empty is ignored; pointers wrap modulo TRACE_DEPTH.
REQ-023 The trace FIFO and counters are not affected by mispredict (only committed state is traced).
REQ-024 Commits with commit_we=1 and commit_areg=0 are traced but never update x0 state.

Reset
REQ-025 On reset low: state=IDLE, watchdog=0, retired_count=0, mispredict_count=0, trace_count=0, trace_valid=0, trace_overflow=0, hang=0, arch_rd_data=0.
REQ-026 A reset asserted mid-operation discards all FIFO contents in the same edge.

Configuration
REQ-027 COMMIT_MON_SHADOW_EN defined: a 32x32 architectural shadow file is updated at commit (if two lanes write the same areg, the youngest lane wins); arch_rd_data is registered with 1-cycle latency and x0 reads 0.
REQ-028 COMMIT_MON_SHADOW_EN undefined: no shadow storage; arch_rd_data is tied to 0.

Structure
REQ-029 Package commit_mon_pkg holds the trace_entry_t struct {pc, areg, data}, the mon_state_t enum and the default parameter constants.
REQ-030 Sub-module trace_fifo (multi-push up to COMMIT_W, single-pop) holds FIFO storage, pointers and the overflow logic.

Verification (COMMIT_W=2, TRACE_DEPTH=4, WDOG_CYCLES=8)
REQ-031 Reset, then 2 lanes valid (pc 0x100, 0x104) -> state RUN; trace_count=2 next cycle; head pc=0x100; retired_count=2.
REQ-032 Fill 3 entries, then push 2 with no pop -> 1 kept (older lane), trace_count=4, trace_overflow=1.
REQ-033 Count=4, pop plus 1 push in the same cycle -> count stays 4, no overflow, head advances.
REQ-034 In RUN, 8 commit-free cycles -> hang=1; next commit -> hang=0, state RUN.
REQ-035 70000 mispredict pulses -> mispredict_count=0xFFFF.
REQ-036 Shadow on: lane0 writes x5=1 and lane1 writes x5=2 in the same cycle -> arch_rd_areg=5 reads 2; a write to x0=7 -> x0 reads 0.

Source files
------------

// File: rtl/commit_mon_pkg.sv
// Shared types and default parameters for the commit monitor slice.
// Holds the trace entry layout, the monitor FSM encoding and a lane popcount.
package commit_mon_pkg;

    localparam int unsigned DEF_COMMIT_W    = 2;
    localparam int unsigned DEF_TRACE_DEPTH = 16;
    localparam int unsigned DEF_WDOG_CYCLES = 1024;
    localparam int unsigned DEF_PREG_W      = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HUNG = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  areg;
        logic [31:0] data;
    } trace_entry_t;

    // Number of retiring lanes; callers zero-extend their strobe to 4 bits
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/commit_monitor_fifo.sv
// trace_fifo: multi-push (up to COMMIT_W lanes per cycle), single-pop trace buffer.
// Valid lanes are packed in lane order; when space runs out the oldest lanes
// that fit are stored, the rest are dropped and a sticky overflow flag is set.
// A pop in the same cycle frees its slot for that cycle's pushes.
module trace_fifo
    import commit_mon_pkg::*;
#(
    parameter int unsigned COMMIT_W = DEF_COMMIT_W,
    parameter int unsigned DEPTH    = DEF_TRACE_DEPTH
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [COMMIT_W-1:0]           i_push_valid,
    input  trace_entry_t [COMMIT_W-1:0]   i_push_entry,
    input  logic                          i_pop,
    output logic                          o_valid,
    output trace_entry_t                  o_head,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_overflow
);

    localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    trace_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_pop;
    logic [COMMIT_W-1:0] w_lane_wr;
    logic [PTR_W-1:0] w_lane_idx [COMMIT_W];
    int unsigned      w_free;
    int unsigned      w_n_valid;
    int unsigned      w_n_push;

    assign w_pop = i_pop & (r_count != '0);

    // Rank each valid lane among older valid lanes; ranks below the free space are written
    always_comb begin
        w_free    = DEPTH - 32'(r_count) + 32'(w_pop);
        w_n_valid = 0;
        w_n_push  = 0;
        w_lane_wr = '0;
        for (int unsigned l = 0; l < COMMIT_W; l++) begin
            w_lane_idx[l] = (r_wr_ptr + PTR_W'(w_n_valid)) & PTR_MASK;
            if (i_push_valid[l]) begin
                if (w_n_valid < w_free) begin
                    w_lane_wr[l] = 1'b1;
                    w_n_push     = w_n_push + 1;
                end
                w_n_valid = w_n_valid + 1;
            end
        end
    end

    // Pointers, occupancy and sticky overflow; reset discards all contents
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= (r_wr_ptr + PTR_W'(w_n_push)) & PTR_MASK;
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr + PTR_W'(1)) & PTR_MASK;
            end
            r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
            if (w_n_valid > w_free) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < COMMIT_W; l++) begin
            if (w_lane_wr[l]) begin
                r_mem[w_lane_idx[l]] <= i_push_entry[l];
            end
        end
    end

    assign o_valid    = (r_count != '0);
    assign o_head     = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/commit_monitor.sv
// commit_monitor: retire-stage observer. Counts retired instructions and
// mispredicts, runs a commit watchdog FSM (IDLE/RUN/HUNG) and feeds a trace FIFO.
// Build option COMMIT_MON_SHADOW_EN adds a 32x32 architectural shadow register
// file readable through arch_rd_areg/arch_rd_data; otherwise arch_rd_data is 0.
module commit_monitor
    import commit_mon_pkg::*;
#(
    parameter int unsigned COMMIT_W    = DEF_COMMIT_W,
    parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH,
    parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES,
    parameter int unsigned PREG_W      = DEF_PREG_W
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [COMMIT_W-1:0]               commit_valid,
    input  logic [COMMIT_W-1:0][31:0]         commit_pc,
    input  logic [COMMIT_W-1:0]               commit_we,
    input  logic [COMMIT_W-1:0][4:0]          commit_areg,
    input  logic [COMMIT_W-1:0][PREG_W-1:0]   commit_preg,
    input  logic [COMMIT_W-1:0][31:0]         commit_data,
    input  logic                              mispredict,
    input  logic                              trace_rd,
    output logic                              trace_valid,
    output logic [31:0]                       trace_pc,
    output logic [4:0]                        trace_areg,
    output logic [31:0]                       trace_data,
    output logic [$clog2(TRACE_DEPTH):0]      trace_count,
    output logic                              trace_overflow,
    output logic [31:0]                       retired_count,
    output logic [15:0]                       mispredict_count,
    output logic                              hang,
    output logic [1:0]                        mon_state,
    input  logic [4:0]                        arch_rd_areg,
    output logic [31:0]                       arch_rd_data
);

    localparam int unsigned     WD_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    mon_state_t      r_state;
    mon_state_t      w_next_state;
    logic [WD_W-1:0] r_wdog;
    logic [WD_W-1:0] w_next_wdog;
    logic            r_hang;
    logic [31:0]     r_retired;
    logic [15:0]     r_mispred;
    logic            w_any_commit;

    trace_entry_t [COMMIT_W-1:0] w_entries;
    trace_entry_t                w_head;

    // Physical tags are not part of the trace or the architectural view
    logic w_unused_preg;
    assign w_unused_preg = ^commit_preg;

    assign w_any_commit = |commit_valid;

    // Watchdog FSM next state: commit-free cycles only count while running
    always_comb begin
        w_next_state = r_state;
        w_next_wdog  = r_wdog;
        case (r_state)
            IDLE: begin
                if (w_any_commit) begin
                    w_next_state = RUN;
                    w_next_wdog  = '0;
                end
            end
            RUN: begin
                if (w_any_commit) begin
                    w_next_wdog = '0;
                end else begin
                    if (r_wdog == WD_LAST) begin
                        w_next_state = HUNG;
                    end
                    w_next_wdog = r_wdog + 1'b1;
                end
            end
            HUNG: begin
                if (w_any_commit) begin
                    w_next_state = RUN;
                    w_next_wdog  = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_wdog  = '0;
            end
        endcase
    end

    // FSM state, watchdog and registered hang flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_wdog  <= '0;
            r_hang  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_wdog  <= w_next_wdog;
            r_hang  <= (w_next_state == HUNG);
        end
    end

    // Retired counter wraps; mispredict counter saturates
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retired <= '0;
            r_mispred <= '0;
        end else begin
            r_retired <= r_retired + 32'(popcount4(4'(commit_valid)));
            if (mispredict && (r_mispred != 16'hFFFF)) begin
                r_mispred <= r_mispred + 16'd1;
            end
        end
    end

    // Per-lane trace entries in program order
    always_comb begin
        w_entries = '0;
        for (int unsigned l = 0; l < COMMIT_W; l++) begin
            w_entries[l].pc   = commit_pc[l];
            w_entries[l].areg = commit_areg[l];
            w_entries[l].data = commit_data[l];
        end
    end

    trace_fifo #(
        .COMMIT_W (COMMIT_W),
        .DEPTH    (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (commit_valid),
        .i_push_entry (w_entries),
        .i_pop        (trace_rd),
        .o_valid      (trace_valid),
        .o_head       (w_head),
        .o_count      (trace_count),
        .o_overflow   (trace_overflow)
    );

    assign trace_pc         = w_head.pc;
    assign trace_areg       = w_head.areg;
    assign trace_data       = w_head.data;
    assign retired_count    = r_retired;
    assign mispredict_count = r_mispred;
    assign hang             = r_hang;
    assign mon_state        = r_state;

`ifdef COMMIT_MON_SHADOW_EN
    logic [31:0] r_shadow [32];
    logic [31:0] r_arch_rd;

    // Query reads pre-update contents; lanes written oldest first so the youngest wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_shadow[i] <= '0;
            end
            r_arch_rd <= '0;
        end else begin
            r_arch_rd <= (arch_rd_areg == 5'd0) ? '0 : r_shadow[arch_rd_areg];
            for (int unsigned l = 0; l < COMMIT_W; l++) begin
                if (commit_valid[l] && commit_we[l] && (commit_areg[l] != 5'd0)) begin
                    r_shadow[commit_areg[l]] <= commit_data[l];
                end
            end
        end
    end

    assign arch_rd_data = r_arch_rd;
`else
    logic w_unused_shadow;
    assign w_unused_shadow = ^{arch_rd_areg, commit_we};
    assign arch_rd_data    = '0;
`endif

endmodule
